// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encodings and default sizing for the counter sequencer
package counter_pkg;

  localparam int DEF_PRESCALE = 4;
  localparam int DEF_WIDTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle count-enable strobe every PRESCALE enabled cycles
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Strobe is combinational so the sequencer can act on the wrapping cycle and register its own outputs.
  assign tick = en && (cnt == LAST);

  // Phase counter: cleared on request, frozen while disabled, wraps after the last phase.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - prescaled up-counter with one-shot/auto-reload runs, pause and abort
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             idle_like, go, tg_en, tg_clr, wrap;

  // Command decode: stop beats pause, pause beats start; the prescaler only runs in RUN with no command.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign go        = idle_like && start && !pause && !stop;
  assign tg_en     = (state_q == ST_RUN) && !pause && !stop;
  assign tg_clr    = stop || go;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rs   (rs),
    .en   (tg_en),
    .clr  (tg_clr),
    .tick (wrap)
  );

  // Next-state and datapath decisions for the run/hold/done sequencer.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      q_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state_d = ST_RUN;
            q_d     = '0;
            limit_d = limit;
            mode_d  = mode;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (wrap) begin
            tick_d = 1'b1;
            if (q_q == limit_q) begin
              done_d = 1'b1;
              if (mode_q) begin
                q_d = '0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              q_d = q_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, count, captured run settings and registered strobes.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign q     = q_q;
  assign tick  = tick_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign state = state_q;

endmodule
